gcd_controller: RTL and testbench

GCD_CONTROLLER -- requirements
Module: gcd_controller

---
 rtl/gcd_pkg.sv | 49 ++++
 rtl/gcd_iter_counter.sv | 29 ++
 rtl/gcd_controller.sv | 96 +++++++++
 tb/tb_gcd_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller: state encoding, widths, iteration limit
// and the Moore output decode.
package gcd_pkg;

  localparam int unsigned DATA_W     = 4;
  localparam int unsigned ITER_W     = 4;
  localparam int unsigned ITER_LIMIT = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TEST  = 3'd2,
    ST_SUBX  = 3'd3,
    ST_SUBY  = 3'd4,
    ST_STORE = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  typedef struct packed {
    logic x_sel;
    logic y_sel;
    logic x_ld;
    logic y_ld;
    logic d_ld;
    logic busy;
    logic done;
    logic err;
  } ctrl_t;

  // Control word seen by the datapath while the FSM sits in state s.
  function automatic ctrl_t ctrl_decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_IDLE:  c = '0;
      ST_LOAD:  begin c.x_ld = 1'b1; c.y_ld = 1'b1; c.busy = 1'b1; end
      ST_TEST:  c.busy = 1'b1;
      ST_SUBX:  begin c.x_sel = 1'b1; c.x_ld = 1'b1; c.busy = 1'b1; end
      ST_SUBY:  begin c.y_sel = 1'b1; c.y_ld = 1'b1; c.busy = 1'b1; end
      ST_STORE: begin c.d_ld = 1'b1; c.busy = 1'b1; end
      ST_DONE:  begin c.done = 1'b1; c.busy = 1'b1; end
      ST_ERR:   begin c.err = 1'b1; c.busy = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gcd_iter_counter.sv
// Subtract-step counter: cleared on an accepted start, bumped once per subtract state,
// flags when the run has used its full iteration budget.
module gcd_iter_counter
  import gcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_inc,
  output logic [ITER_W-1:0] o_count,
  output logic              o_at_limit_c
);

  logic [ITER_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + ITER_W'(1);
    end
  end

  assign o_count      = r_count;
  assign o_at_limit_c = (r_count == ITER_W'(ITER_LIMIT));

endmodule

// File: rtl/gcd_controller.sv
// Moore FSM sequencing a subtract-based 4-bit GCD datapath; control outputs are
// registered copies of the decode of the state being entered.
module gcd_controller
  import gcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              x_neq_y,
  input  logic              x_lt_y,
  output logic              x_sel,
  output logic              y_sel,
  output logic              x_ld,
  output logic              y_ld,
  output logic              d_ld,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  state_e r_state;
  state_e w_state_next;
  ctrl_t  r_ctrl;
  logic   w_cnt_clr;
  logic   w_cnt_inc;
  logic   w_at_limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_state_next;
      r_ctrl  <= ctrl_decode(w_state_next);
    end
  end

  // The limit test sits ahead of the subtract branches so the count never passes 15.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_LOAD;
          w_cnt_clr    = 1'b1;
        end
      end
      ST_LOAD: w_state_next = ST_TEST;
      ST_TEST: begin
        if (!x_neq_y) begin
          w_state_next = ST_STORE;
        end else if (w_at_limit) begin
          w_state_next = ST_ERR;
        end else if (x_lt_y) begin
          w_state_next = ST_SUBY;
        end else begin
          w_state_next = ST_SUBX;
        end
      end
      ST_SUBX: begin
        w_state_next = ST_TEST;
        w_cnt_inc    = 1'b1;
      end
      ST_SUBY: begin
        w_state_next = ST_TEST;
        w_cnt_inc    = 1'b1;
      end
      ST_STORE: w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      ST_ERR:   w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  gcd_iter_counter u_iter (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_cnt_clr),
    .i_inc        (w_cnt_inc),
    .o_count      (iter_cnt),
    .o_at_limit_c (w_at_limit)
  );

  assign x_sel = r_ctrl.x_sel;
  assign y_sel = r_ctrl.y_sel;
  assign x_ld  = r_ctrl.x_ld;
  assign y_ld  = r_ctrl.y_ld;
  assign d_ld  = r_ctrl.d_ld;
  assign busy  = r_ctrl.busy;
  assign done  = r_ctrl.done;
  assign err   = r_ctrl.err;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller driving a falling-edge 4-bit GCD datapath; run outcomes
// are predicted by a plain subtract-loop model of Euclid's algorithm.
module tb_gcd_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic       x_neq_y;
  logic       x_lt_y;
  logic       x_sel;
  logic       y_sel;
  logic       x_ld;
  logic       y_ld;
  logic       d_ld;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] iter_cnt;

  logic [3:0] op_x;
  logic [3:0] op_y;
  logic [3:0] dp_x;
  logic [3:0] dp_y;
  logic [3:0] dp_d;

  int n_chk;
  int n_err;

  gcd_controller dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x_neq_y  (x_neq_y),
    .x_lt_y   (x_lt_y),
    .x_sel    (x_sel),
    .y_sel    (y_sel),
    .x_ld     (x_ld),
    .y_ld     (y_ld),
    .d_ld     (d_ld),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .iter_cnt (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: registers load on the falling edge, flags are combinational.
  always @(negedge clk) begin
    if (reset) begin
      dp_x <= 4'd0;
      dp_y <= 4'd0;
      dp_d <= 4'd0;
    end else begin
      if (x_ld) dp_x <= x_sel ? (dp_x - dp_y) : op_x;
      if (y_ld) dp_y <= y_sel ? (dp_y - dp_x) : op_y;
      if (d_ld) dp_d <= dp_x;
    end
  end
  assign x_neq_y = (dp_x != dp_y);
  assign x_lt_y  = (dp_x < dp_y);

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int outs_word();
    return int'({x_sel, y_sel, x_ld, y_ld, d_ld, busy, done, err});
  endfunction

  // One run; restart_cyc pulses start mid-run, hold keeps start high throughout.
  task automatic run(input logic [3:0] a, input logic [3:0] b,
                     input int restart_cyc, input bit hold);
    int mx, my, k, end_cyc, done_cyc, err_cyc, n_done, n_errp, res;
    bit exp_err, dld_seen, busy_bad;
    string t;
    mx = int'(a); my = int'(b); k = 0; exp_err = 1'b0;
    while (mx != my) begin
      if (k == 15) begin exp_err = 1'b1; break; end
      if (mx < my) my = my - mx; else mx = mx - my;
      k++;
    end
    end_cyc = exp_err ? (3 + 2 * k) : (4 + 2 * k);
    t = $sformatf("gcd(%0d,%0d)", a, b);

    op_x = a; op_y = b; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    done_cyc = 0; err_cyc = 0; n_done = 0; n_errp = 0; res = -1;
    dld_seen = 1'b0; busy_bad = 1'b0;
    for (int c = 1; c <= end_cyc; c++) begin
      if (done) begin n_done++; if (done_cyc == 0) done_cyc = c; res = int'(dp_d); end
      if (err) begin n_errp++; if (err_cyc == 0) err_cyc = c; end
      if (d_ld) dld_seen = 1'b1;
      if (!busy) busy_bad = 1'b1;
      if (c == end_cyc) begin
        chk({t, " iter_cnt at end"}, int'(iter_cnt), k);
        break;
      end
      if (!hold) start = (c + 1 == restart_cyc);
      @(posedge clk); #1;
    end
    if (exp_err) begin
      chk({t, " err cycle"}, err_cyc, end_cyc);
      chk({t, " done pulses"}, n_done, 0);
      chk({t, " d_ld seen"}, int'(dld_seen), 0);
    end else begin
      chk({t, " done cycle"}, done_cyc, end_cyc);
      chk({t, " result"}, res, mx);
      chk({t, " err pulses"}, n_errp, 0);
    end
    chk({t, " busy dropped"}, int'(busy_bad), 0);
    @(posedge clk); #1;
    chk({t, " idle busy"}, int'(busy), 0);
    chk({t, " iter_cnt held"}, int'(iter_cnt), k);
    if (hold) begin
      @(posedge clk); #1;
      chk({t, " restart LOAD"}, outs_word(), 8'b0011_0100);
      chk({t, " restart iter clear"}, int'(iter_cnt), 0);
      start = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; op_x = 4'd0; op_y = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", outs_word(), 0);
    chk("reset iter_cnt", int'(iter_cnt), 0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("start under reset", int'(busy), 0);
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    run(4'd5, 4'd5, 0, 1'b0);
    run(4'd12, 4'd8, 0, 1'b0);
    run(4'd15, 4'd1, 0, 1'b0);
    run(4'd6, 4'd0, 0, 1'b0);
    run(4'd0, 4'd0, 0, 1'b0);
    run(4'd0, 4'd9, 0, 1'b0);
    run(4'd12, 4'd8, 2, 1'b0);
    run(4'd3, 4'd3, 0, 1'b1);

    // Reset in the second SUBX cycle of a long run.
    op_x = 4'd15; op_y = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid-run in SUBX", outs_word(), 8'b1010_0100);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid-run reset outputs", outs_word(), 0);
    chk("mid-run reset iter_cnt", int'(iter_cnt), 0);
    @(posedge clk); #1;
    chk("post-reset idle", outs_word(), 0);
    run(4'd9, 4'd6, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
